// File: rtl/cgra_ctx_pkg.sv
// -----------------------------------------------------------------------------
// cgra_ctx_pkg
// Shared types and constants for the CGRA context control plane:
//   - control FSM state encoding
//   - default array geometry and tile count
//   - context header field positions
// -----------------------------------------------------------------------------
package cgra_ctx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_NB_ROWS = 4;
    localparam int unsigned DEF_NB_COLS = 4;
    localparam int unsigned NB_TILES    = DEF_NB_ROWS * DEF_NB_COLS;

    // Context header layout
    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned LEN_MSB   = 7;
    localparam int unsigned LEN_LSB   = 0;

endpackage

// File: rtl/cgra_ctx_bank.sv
// -----------------------------------------------------------------------------
// cgra_ctx_bank / cgra_ctx_bank_cut
// Context memory bank: a read-only array (Mem) preloaded hierarchically via
// <bank>.cut.Mem, with a registered synchronous read (1-cycle latency).
// There is no write port.
// Ports:
//   i_clk   rising-edge clock
//   i_en    read enable; o_data updates on the next edge only when set
//   i_addr  word address
//   o_data  registered read data
// -----------------------------------------------------------------------------
module cgra_ctx_bank_cut
    import cgra_ctx_pkg::*;
#(
    parameter int unsigned CTX_WIDTH = 32,
    parameter int unsigned CTX_DEPTH = 64,
    parameter int unsigned ADDR_W    = $clog2(CTX_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_en,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic [CTX_WIDTH-1:0] o_data
);

    logic [CTX_WIDTH-1:0] Mem [CTX_DEPTH];
    logic [CTX_WIDTH-1:0] r_q;

    // Macro-style read port: output register has no reset, consumers
    // qualify it with their own read-valid flag.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_q <= Mem[i_addr];
        end
    end

    assign o_data = r_q;

endmodule

module cgra_ctx_bank
    import cgra_ctx_pkg::*;
#(
    parameter int unsigned CTX_WIDTH = 32,
    parameter int unsigned CTX_DEPTH = 64,
    parameter int unsigned ADDR_W    = $clog2(CTX_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_en,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic [CTX_WIDTH-1:0] o_data
);

    cgra_ctx_bank_cut #(
        .CTX_WIDTH (CTX_WIDTH),
        .CTX_DEPTH (CTX_DEPTH),
        .ADDR_W    (ADDR_W)
    ) cut (
        .i_clk  (i_clk),
        .i_en   (i_en),
        .i_addr (i_addr),
        .o_data (o_data)
    );

endmodule

// File: rtl/cgra_ctx_top.sv
// -----------------------------------------------------------------------------
// cgra_ctx_top
// Control-plane top of a NB_ROWS x NB_COLS CGRA. Fetches one context header
// per tile from two banks (IM_BANK1: tiles 0..N/2-1, IM_BANK2: the rest),
// then runs each valid tile's countdown and reports sticky completion.
// Ports:
//   Clk               rising-edge clock
//   Reset             asynchronous active-low reset
//   DMA_Clk           fetch-enable level sampled on Clk (not a clock)
//   Initn             synchronous active-low soft init
//   Context_Fetch_En  starts a fetch, honoured only in IDLE
//   End_Exec_O        per-tile execution done, sticky
// -----------------------------------------------------------------------------
module cgra_ctx_top
    import cgra_ctx_pkg::*;
#(
    parameter int unsigned NB_ROWS      = DEF_NB_ROWS,
    parameter int unsigned NB_COLS      = DEF_NB_COLS,
    parameter int unsigned CTX_WIDTH    = 32,
    parameter int unsigned CTX_DEPTH    = 64,
    parameter int unsigned CTX_PER_TILE = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       DMA_Clk,
    input  logic                       Initn,
    input  logic                       Context_Fetch_En,
    output logic [NB_ROWS*NB_COLS-1:0] End_Exec_O
);

    localparam int unsigned N_TILES = NB_ROWS * NB_COLS;
    localparam int unsigned HALF    = N_TILES / 2;
    localparam int unsigned IDX_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned J_W     = IDX_W + 1;
    localparam int unsigned A_W     = $clog2(CTX_DEPTH);
    localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;

    state_t               r_state;
    state_t               w_next;
    logic [J_W-1:0]       r_j;
    logic                 r_rd_vld;
    logic [IDX_W-1:0]     r_rd_idx;
    logic                 w_issue;
    logic                 w_cap_last;
    logic                 w_all_done;
    logic [A_W-1:0]       w_addr;
    logic [CTX_WIDTH-1:0] w_hdr1;
    logic [CTX_WIDTH-1:0] w_hdr2;
    logic [N_TILES-1:0]   w_valid;
    logic [N_TILES-1:0]   w_end;
    logic                 w_unused_hdr_bits;

    // One read per DMA_Clk-enabled cycle until all header pairs are issued.
    assign w_issue    = (r_state == ST_FETCH) && DMA_Clk && (r_j != J_W'(HALF));
    assign w_addr     = A_W'(r_j * CTX_PER_TILE);
    assign w_cap_last = r_rd_vld && (r_rd_idx == IDX_W'(HALF - 1));
    assign w_all_done = &(~w_valid | w_end);

    // Only the valid bit and length field of a header carry meaning.
    assign w_unused_hdr_bits = ^{w_hdr1, w_hdr2};

    cgra_ctx_bank #(
        .CTX_WIDTH (CTX_WIDTH),
        .CTX_DEPTH (CTX_DEPTH),
        .ADDR_W    (A_W)
    ) IM_BANK1 (
        .i_clk  (Clk),
        .i_en   (w_issue),
        .i_addr (w_addr),
        .o_data (w_hdr1)
    );

    cgra_ctx_bank #(
        .CTX_WIDTH (CTX_WIDTH),
        .CTX_DEPTH (CTX_DEPTH),
        .ADDR_W    (A_W)
    ) IM_BANK2 (
        .i_clk  (Clk),
        .i_en   (w_issue),
        .i_addr (w_addr),
        .o_data (w_hdr2)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (Context_Fetch_En) w_next = ST_FETCH;
            ST_FETCH: if (w_cap_last)       w_next = ST_EXEC;
            ST_EXEC:  if (w_all_done)       w_next = ST_DONE;
            ST_DONE:  w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
        if (!Initn) begin
            w_next = ST_IDLE;
        end
    end

    // Fetch pointer and read-tracking: r_rd_vld/r_rd_idx follow the bank
    // latency so a read issued just before a stall is still captured.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_j      <= '0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
        end else if (!Initn) begin
            r_j      <= '0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_idx <= r_j[IDX_W-1:0];
                r_j      <= r_j + 1'b1;
            end else if (r_state == ST_IDLE) begin
                r_j <= '0;
            end
        end
    end

    for (genvar t = 0; t < N_TILES; t++) begin : g_tile
        localparam int unsigned LOC = t % HALF;

        logic [CTX_WIDTH-1:0] w_hdr;
        logic                 w_cap;
        logic                 r_valid;
        logic                 r_end;
        logic [LEN_W-1:0]     r_cnt;

        if (t < HALF) begin : g_lo
            assign w_hdr = w_hdr1;
        end else begin : g_hi
            assign w_hdr = w_hdr2;
        end

        assign w_cap = r_rd_vld && (r_rd_idx == IDX_W'(LOC));

        // Capture loads the counter directly, so the counter already holds L
        // on the edge that enters EXEC (the last capture edge).
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                r_valid <= 1'b0;
                r_end   <= 1'b0;
                r_cnt   <= '0;
            end else if (!Initn) begin
                r_valid <= 1'b0;
                r_end   <= 1'b0;
                r_cnt   <= '0;
            end else if (w_cap) begin
                r_valid <= w_hdr[VALID_BIT];
                r_cnt   <= w_hdr[LEN_MSB:LEN_LSB];
                r_end   <= 1'b0;
            end else if ((r_state == ST_EXEC) && r_valid) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_end <= 1'b1;
                end
            end
        end

        assign w_valid[t] = r_valid;
        assign w_end[t]   = r_end;
    end

    assign End_Exec_O = w_end;

endmodule

// File: tb/tb_cgra_ctx_top.sv
module tb_cgra_ctx_top;
    import cgra_ctx_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        DMA_Clk;
    logic        Initn;
    logic        Context_Fetch_En;
    logic [15:0] End_Exec_O;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0][31:0] hdr;
        int                stall;
        int                exp_fetch;
        int                exp_done;
        logic [15:0]       exp_final;
    } vec_t;

    vec_t tbl [5];

    cgra_ctx_top #(
        .NB_ROWS      (4),
        .NB_COLS      (4),
        .CTX_WIDTH    (32),
        .CTX_DEPTH    (64),
        .CTX_PER_TILE (4)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .DMA_Clk          (DMA_Clk),
        .Initn            (Initn),
        .Context_Fetch_En (Context_Fetch_En),
        .End_Exec_O       (End_Exec_O)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(negedge Clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Completion expected k edges after EXEC entry: valid tiles end at edge L+1.
    function automatic logic [15:0] model_end(input logic [15:0][31:0] h, input int k);
        logic [15:0] r;
        logic [31:0] w;
        r = '0;
        for (int t = 0; t < 16; t++) begin
            w    = h[t];
            r[t] = w[31] && (k >= int'(w[7:0]) + 1);
        end
        return r;
    endfunction

    task automatic load(input logic [15:0][31:0] h);
        for (int a = 0; a < 64; a++) begin
            dut.IM_BANK1.cut.Mem[a] = 32'hFFFF_FFFF;
            dut.IM_BANK2.cut.Mem[a] = 32'hFFFF_FFFF;
        end
        for (int t = 0; t < 8; t++) begin
            dut.IM_BANK1.cut.Mem[t*4] = h[t];
            dut.IM_BANK2.cut.Mem[t*4] = h[t+8];
        end
    endtask

    task automatic wait_exec(input int stall, output int n);
        n = 0;
        while ((dut.r_state != ST_EXEC) && (n < 40)) begin
            if (n == 3 + stall) DMA_Clk = 1'b1;
            else if (n == 3)    DMA_Clk = 1'b0;
            nxt();
            n++;
        end
        DMA_Clk = 1'b1;
    endtask

    task automatic start_run(input logic [15:0][31:0] h, input int stall, output int n);
        Initn            = 1'b0;
        DMA_Clk          = 1'b1;
        Context_Fetch_En = 1'b0;
        nxt();
        chk("initn_clear_end", 32'(End_Exec_O), 32'h0);
        Initn = 1'b1;
        load(h);
        Context_Fetch_En = 1'b1;
        nxt();
        chk("enter_fetch", 32'(dut.r_state), 32'(ST_FETCH));
        Context_Fetch_En = 1'b0;
        wait_exec(stall, n);
    endtask

    initial begin
        int n;
        logic [15:0][31:0] h;

        for (int t = 0; t < 16; t++) begin
            tbl[0].hdr[t] = 32'h8000_0003;
            tbl[1].hdr[t] = 32'h8000_0000 | t;
            tbl[2].hdr[t] = (t < 8) ? 32'h8000_0002 : 32'h0000_0002;
            tbl[3].hdr[t] = 32'h8ABC_D000 | t;
            tbl[4].hdr[t] = 32'h0000_000A;
        end
        tbl[0].stall = 0; tbl[0].exp_fetch = 9;  tbl[0].exp_done = 5;  tbl[0].exp_final = 16'hFFFF;
        tbl[1].stall = 0; tbl[1].exp_fetch = 9;  tbl[1].exp_done = 17; tbl[1].exp_final = 16'hFFFF;
        tbl[2].stall = 0; tbl[2].exp_fetch = 9;  tbl[2].exp_done = 4;  tbl[2].exp_final = 16'h00FF;
        tbl[3].stall = 5; tbl[3].exp_fetch = 14; tbl[3].exp_done = 17; tbl[3].exp_final = 16'hFFFF;
        tbl[4].stall = 0; tbl[4].exp_fetch = 9;  tbl[4].exp_done = 1;  tbl[4].exp_final = 16'h0000;

        Reset            = 1'b0;
        Initn            = 1'b0;
        DMA_Clk          = 1'b0;
        Context_Fetch_En = 1'b0;
        repeat (2) nxt();
        chk("reset_end", 32'(End_Exec_O), 32'h0);
        chk("reset_state", 32'(dut.r_state), 32'(ST_IDLE));

        Reset = 1'b1;
        nxt();
        Context_Fetch_En = 1'b1;
        nxt();
        chk("initn_low_blocks_fetch", 32'(dut.r_state), 32'(ST_IDLE));
        Initn            = 1'b1;
        Context_Fetch_En = 1'b0;
        nxt();
        chk("idle_without_enable", 32'(dut.r_state), 32'(ST_IDLE));

        for (int i = 0; i < 5; i++) begin
            start_run(tbl[i].hdr, tbl[i].stall, n);
            chk($sformatf("v%0d_fetch_cycles", i), 32'(n), 32'(tbl[i].exp_fetch));
            chk($sformatf("v%0d_entry_end", i), 32'(End_Exec_O), 32'h0);
            for (int k = 1; k <= tbl[i].exp_done; k++) begin
                nxt();
                chk($sformatf("v%0d_end_k%0d", i, k), 32'(End_Exec_O), 32'(model_end(tbl[i].hdr, k)));
                chk($sformatf("v%0d_state_k%0d", i, k), 32'(dut.r_state),
                    (k == tbl[i].exp_done) ? 32'(ST_DONE) : 32'(ST_EXEC));
            end
            Context_Fetch_En = 1'b1;
            repeat (3) nxt();
            chk($sformatf("v%0d_final_end", i), 32'(End_Exec_O), 32'(tbl[i].exp_final));
            chk($sformatf("v%0d_hold_done", i), 32'(dut.r_state), 32'(ST_DONE));
            Context_Fetch_En = 1'b0;
        end

        // Initn pulse mid-EXEC, then restart from the untouched banks.
        for (int t = 0; t < 16; t++) h[t] = (t < 4) ? 32'h8000_0001 : 32'h8000_00C8;
        start_run(h, 0, n);
        chk("a_fetch_cycles", 32'(n), 32'd9);
        repeat (5) nxt();
        chk("a_partial_end", 32'(End_Exec_O), 32'h000F);
        chk("a_in_exec", 32'(dut.r_state), 32'(ST_EXEC));
        Initn = 1'b0;
        nxt();
        chk("a_initn_end", 32'(End_Exec_O), 32'h0);
        chk("a_initn_state", 32'(dut.r_state), 32'(ST_IDLE));
        Initn            = 1'b1;
        Context_Fetch_En = 1'b1;
        nxt();
        chk("a_refetch", 32'(dut.r_state), 32'(ST_FETCH));
        Context_Fetch_En = 1'b0;
        wait_exec(0, n);
        chk("a_refetch_cycles", 32'(n), 32'd9);
        nxt();
        chk("a_re_end_k1", 32'(End_Exec_O), 32'h0);
        nxt();
        chk("a_re_end_k2", 32'(End_Exec_O), 32'h000F);

        // Asynchronous reset while in DONE.
        start_run(tbl[0].hdr, 0, n);
        repeat (5) nxt();
        chk("b_done", 32'(dut.r_state), 32'(ST_DONE));
        chk("b_done_end", 32'(End_Exec_O), 32'hFFFF);
        #2;
        Reset = 1'b0;
        #1;
        chk("b_async_end", 32'(End_Exec_O), 32'h0);
        chk("b_async_state", 32'(dut.r_state), 32'(ST_IDLE));
        @(negedge Clk);
        Reset = 1'b1;
        nxt();
        chk("b_after_reset", 32'(dut.r_state), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
